// File: rtl/led_blink_arbiter_if.sv
// rtl/led_blink_arbiter_if.sv - request/rate inputs and LED/grant outputs of the LED blink arbiter
interface led_blink_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] rate;
  logic               led;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (
    output req,
    output rate,
    input  led,
    input  grant,
    input  busy
  );

  modport slave (
    input  req,
    input  rate,
    output led,
    output grant,
    output busy
  );
endinterface

// File: rtl/led_blink_arbiter.sv
// rtl/led_blink_arbiter.sv - shares one status LED between N_REQ blink-pattern requesters
// Optional feature macro: LED_BLINK_ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority)
module led_blink_arbiter #(
  parameter int CLK_HZ  = 48_000_000,
  parameter int TICK_HZ = 8,
  parameter int N_REQ   = 4
) (
  input  logic               clk,
  input  logic               reset,
  led_blink_arbiter_if.slave bus
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW       = $clog2(N_REQ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       rate_q, rate_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             led_q, led_d;
  logic [N_REQ-1:0] grant_q, grant_d;
`ifdef LED_BLINK_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]    last_q, last_d;
  int               rr_idx;
`endif

  logic             tick;
  logic             owner_req;
  logic [1:0]       hp_last;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic             do_grant;
  logic [1:0]       rate_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_rate
    assign rate_arr[g] = bus.rate[2*g +: 2];
  end

  assign tick      = (presc_q == PRESC_MAX);
  assign owner_req = bus.req[owner_q];

  assign bus.led   = led_q;
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != S_IDLE);

  // Last phase index of a half-period for the latched owner rate (HP-1 ticks)
  always_comb begin
    case (rate_q)
      2'd1:    hp_last = 2'd3;
      2'd2:    hp_last = 2'd1;
      default: hp_last = 2'd0;
    endcase
  end

`ifdef LED_BLINK_ARB_ROUND_ROBIN_EN
  // Round-robin winner: first requester after the last owner, wrapping around
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = int'(last_q) + 1 + k;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      if (!win_found && bus.req[IW'(rr_idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(rr_idx);
      end
    end
  end
`else
  // Fixed-priority winner: lowest requesting index
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[IW'(i)]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`endif

  // Blink FSM: arbitration at flash boundaries, owner drop wins over any tick
  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + 1'b1;
    phase_d  = phase_q;
    rate_d   = rate_q;
    owner_d  = owner_q;
    led_d    = led_q;
    grant_d  = grant_q;
    do_grant = 1'b0;
`ifdef LED_BLINK_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        led_d   = 1'b0;
        grant_d = '0;
        if (win_found) do_grant = 1'b1;
      end
      S_ON: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          led_d   = 1'b0;
          grant_d = '0;
        end else if (tick) begin
          if (rate_q == 2'd0) begin
            // solid owner yields to a different winner on every tick
            if (win_idx != owner_q) do_grant = 1'b1;
          end else if (phase_q == hp_last) begin
            state_d = S_OFF;
            led_d   = 1'b0;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_OFF: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          led_d   = 1'b0;
          grant_d = '0;
        end else if (tick) begin
          if (phase_q == hp_last) begin
            if (win_found) begin
              do_grant = 1'b1;
            end else begin
              state_d = S_IDLE;
              led_d   = 1'b0;
              grant_d = '0;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = 1'b0;
        grant_d = '0;
      end
    endcase
    if (do_grant) begin
      state_d = S_ON;
      led_d   = 1'b1;
      grant_d = N_REQ'(1) << win_idx;
      owner_d = win_idx;
      rate_d  = rate_arr[win_idx];
      phase_d = '0;
      presc_d = '0;
`ifdef LED_BLINK_ARB_ROUND_ROBIN_EN
      last_d  = win_idx;
`endif
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      rate_q  <= '0;
      owner_q <= '0;
      led_q   <= 1'b0;
      grant_q <= '0;
`ifdef LED_BLINK_ARB_ROUND_ROBIN_EN
      last_q  <= IW'(N_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      owner_q <= owner_d;
      led_q   <= led_d;
      grant_q <= grant_d;
`ifdef LED_BLINK_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end
endmodule
